ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Byte-stream program loader upstream of the MAR and 16x8 RAM.
//  Accepts framed bytes from a UART receiver and writes them into RAM through the MAR.
//  Per byte it issues an MAR load, then a RAM write, and holds the CPU for the whole frame.
//  Lets programs be loaded without resynthesising the RAM init block.
// PARAMETERS
//  ADDR_W     4       RAM/MAR address width; RAM depth = 2**ADDR_W
//  DATA_W     8       data bus and byte width
//  SYNC_BYTE  8'hA5   frame start marker
//  TIMEOUT    1000    max idle clocks between bytes inside a frame before abort
// PORTS
//  clk        in   1       system clock, all state updates on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  rx_data    in   DATA_W  incoming byte
//  rx_valid   in   1       rx_data valid; byte taken when rx_valid & rx_ready
//  rx_ready   out  1       loader can accept a byte this cycle
//  mar_addr   out  ADDR_W  address presented to MAR addr_in
//  mar_wr     out  1       MAR load strobe
//  bus_out    out  DATA_W  byte to drive onto RAM data bus
//  bus_oe     out  1       top level drives bus_out onto data bus when 1 (else Z)
//  ram_wr     out  1       RAM write strobe
//  cpu_hold   out  1       CPU held in reset while 1
//  done       out  1       1-cycle pulse: frame completed, checksum good
//  err        out  1       sticky: frame aborted or bad checksum; cleared on next SYNC accept
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; rx_ready=1; mar_wr=ram_wr=bus_oe=0;
//    bus_out=0; mar_addr=0; cpu_hold=0; done=0; err=0; counters cleared.
//  Frame: SYNC_BYTE, ADDR (low ADDR_W bits used, upper ignored),
//    LEN (1..2**ADDR_W; 0 means 2**ADDR_W), LEN data bytes, CSUM.
//  Checksum rule: (sum of data bytes + CSUM) mod 2**DATA_W must be 0.
//  States:
//   IDLE  : rx_ready=1; SYNC_BYTE -> HDR_A, clear err, cpu_hold=1; other bytes dropped.
//   HDR_A : accept byte -> latch addr ptr -> HDR_L.
//   HDR_L : accept byte -> latch remaining count, clear sum -> DATA.
//   DATA  : accept byte -> latch into bus_out, add to sum -> MAR.
//   MAR   : rx_ready=0; mar_wr=1, mar_addr=ptr (1 cycle) -> WR.
//   WR    : rx_ready=0; bus_oe=1, ram_wr=1 (1 cycle);
//           ptr+=1 mod 2**ADDR_W; count-=1; count==0 -> CSUM else DATA.
//   CSUM  : accept byte; good -> done pulse next cycle; bad -> err=1; both -> IDLE.
//  Per data byte: accept at cycle k; mar_wr at k+1; ram_wr/bus_oe at k+2;
//    rx_ready=1 again at k+3.
//  mar_wr and ram_wr are never high in the same cycle.
//  bus_oe=1 only in WR; mar_addr holds its last value otherwise.
//  Address wrap: ptr 15 + 1 -> 0; a 16-byte frame from ADDR=k covers all 16 locations.
//  Timeout: in HDR_A/HDR_L/DATA/CSUM, idle counter counts cycles without accept.
//    Reaching TIMEOUT -> err=1, IDLE. Counter resets on every accept.
//  Writes are not rolled back on abort or bad checksum; err flags the image invalid.
//  cpu_hold is 1 from SYNC accept through the cycle the FSM returns to IDLE.
//    It drops to 0 together with the done pulse or the err set.
//  SYNC_BYTE received inside a frame is treated as ordinary data (no resync).
//  Reset mid-frame: immediate IDLE, strobes low, cpu_hold=0.
//    RAM contents written so far persist.
// TESTING
//  Frame A5,00,03,11,22,33,CSUM=9A -> RAM[0..2]=11,22,33; done pulse; err=0.
//  Per-byte timing: accept at k -> mar_wr@k+1 only, ram_wr+bus_oe@k+2 only, rx_ready@k+3.
//  A5,0E,04,01,02,03,04,F6 -> RAM[14]=01,[15]=02,[0]=03,[1]=04 (wrap); done.
//  LEN=00 with 16 bytes + correct CSUM -> all 16 locations written; done.
//  Bad CSUM -> data written, err=1, no done, cpu_hold drops; next A5 clears err.
//  Stall TIMEOUT cycles after 2nd data byte -> err=1, IDLE, cpu_hold=0.
//  rst_n pulsed low mid-WR -> strobes low at once, IDLE, cpu_hold=0.

Source files
------------

// File: rtl/ram_loader.sv
// Framed byte-stream loader: SYNC, ADDR, LEN, LEN data bytes, CSUM.
// Each data byte becomes an MAR load followed by a RAM write while the CPU is held.
module ram_loader #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
  parameter int                TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mar_wr,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              ram_wr,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // state  | meaning
  // IDLE   | waiting for SYNC_BYTE, other bytes dropped
  // HDR_A  | waiting for start address byte
  // HDR_L  | waiting for length byte
  // DATA   | waiting for next data byte
  // MAR    | MAR load strobe for the byte just taken
  // WR     | RAM write strobe, bus driven, advance pointer/count
  // CSUM   | waiting for checksum byte
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_A, S_HDR_L, S_DATA, S_MAR, S_WR, S_CSUM
  } state_t;

  localparam int                 CNT_W    = ADDR_W + 1;
  localparam int                 TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(2 ** ADDR_W);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   bus_q;
  logic [ADDR_W-1:0]   mar_q;
  logic [TMR_W-1:0]    tmr;
  logic                done_q;
  logic                err_q;
  logic                hold_q;

  logic                accept;
  logic                waiting;
  logic                timeout;
  logic                csum_good;
  logic                sync_seen;

  always_comb begin
    rx_ready  = 1'b1;
    mar_wr    = 1'b0;
    ram_wr    = 1'b0;
    bus_oe    = 1'b0;
    waiting   = 1'b0;
    state_nxt = state;

    case (state)
      S_MAR: begin
        rx_ready = 1'b0;
        mar_wr   = 1'b1;
      end
      S_WR: begin
        rx_ready = 1'b0;
        ram_wr   = 1'b1;
        bus_oe   = 1'b1;
      end
      S_HDR_A, S_HDR_L, S_DATA, S_CSUM: waiting = 1'b1;
      default: ;
    endcase

    accept    = rx_valid & rx_ready;
    timeout   = waiting & ~accept & (tmr == '0);
    sync_seen = (state == S_IDLE) & accept & (rx_data == SYNC_BYTE);
    csum_good = ((sum + rx_data) == '0);

    case (state)
      S_IDLE:  if (sync_seen) state_nxt = S_HDR_A;
      S_HDR_A: if (timeout) state_nxt = S_IDLE; else if (accept) state_nxt = S_HDR_L;
      S_HDR_L: if (timeout) state_nxt = S_IDLE; else if (accept) state_nxt = S_DATA;
      S_DATA:  if (timeout) state_nxt = S_IDLE; else if (accept) state_nxt = S_MAR;
      S_MAR:   state_nxt = S_WR;
      S_WR:    state_nxt = (cnt == CNT_ONE) ? S_CSUM : S_DATA;
      S_CSUM:  if (timeout || accept) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Inter-byte watchdog: reloads on every accept and outside the waiting states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmr <= TMR_LOAD;
    else if (!waiting || accept) tmr <= TMR_LOAD;
    else if (tmr != '0)        tmr <= tmr - TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      cnt   <= '0;
      sum   <= '0;
      bus_q <= '0;
      mar_q <= '0;
    end else begin
      case (state)
        S_HDR_A: if (accept) ptr <= rx_data[ADDR_W-1:0];
        S_HDR_L: if (accept) begin
          // A length of zero in the low bits means a full-depth frame.
          cnt <= (rx_data[ADDR_W-1:0] == '0) ? CNT_FULL : {1'b0, rx_data[ADDR_W-1:0]};
          sum <= '0;
        end
        S_DATA: if (accept) begin
          bus_q <= rx_data;
          sum   <= sum + rx_data;
          mar_q <= ptr;
        end
        S_WR: begin
          ptr <= ptr + ADDR_W'(1);
          cnt <= cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      done_q <= (state == S_CSUM) & accept & csum_good;
      hold_q <= (state_nxt != S_IDLE);
      if (sync_seen)
        err_q <= 1'b0;
      else if (timeout || ((state == S_CSUM) && accept && !csum_good))
        err_q <= 1'b1;
    end
  end

  assign mar_addr = mar_q;
  assign bus_out  = bus_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: frame table plus hand-written timing,
// timeout and mid-write reset sequences, with a behavioural MAR/RAM model.
module tb_ram_loader;

  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] mar_addr;
  logic       mar_wr;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       ram_wr;
  logic       cpu_hold;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  ram_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mar_addr(mar_addr), .mar_wr(mar_wr),
    .bus_out(bus_out), .bus_oe(bus_oe), .ram_wr(ram_wr),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // External MAR + RAM as the loader sees them
  logic [3:0] mar_reg = 4'd0;
  logic [7:0] mem     [16];
  logic [7:0] exp_mem [16];
  int         overlap = 0;

  initial for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end

  always @(posedge clk) begin
    if (mar_wr) mar_reg <= mar_addr;
    if (ram_wr) mem[mar_reg] <= bus_out;
    if (mar_wr && ram_wr) overlap <= overlap + 1;
  end

  typedef struct {
    logic [7:0]   addr;
    logic [7:0]   len;
    logic [127:0] data;
    logic [7:0]   csum;
    logic         exp_done;
    logic         exp_err;
  } frame_t;

  frame_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for rx_ready, then presents the byte for exactly one accept edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin step(); n++; end
    if (rx_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL rx_ready_wait actual=%0b required=1", rx_ready);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic chk_mem(input string name);
    int diffs = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== exp_mem[i]) diffs++;
    chk(name, diffs, 0);
  endtask

  task automatic run_frame(input frame_t f, input int idx);
    int n;
    n = (f.len[3:0] == 4'd0) ? 16 : int'(f.len[3:0]);
    send_byte(8'hA5);
    chk($sformatf("f%0d_hold_on", idx), cpu_hold, 1);
    chk($sformatf("f%0d_err_clr", idx), err, 0);
    send_byte(f.addr);
    send_byte(f.len);
    for (int i = 0; i < n; i++) begin
      send_byte(f.data[8*i +: 8]);
      exp_mem[(int'(f.addr[3:0]) + i) % 16] = f.data[8*i +: 8];
    end
    send_byte(f.csum);
    chk($sformatf("f%0d_done", idx), done, f.exp_done);
    chk($sformatf("f%0d_err", idx), err, f.exp_err);
    chk($sformatf("f%0d_hold_off", idx), cpu_hold, 0);
    step();
    chk($sformatf("f%0d_done_pulse", idx), done, 0);
    chk_mem($sformatf("f%0d_ram", idx));
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    tbl[0] = '{addr:8'h00, len:8'h03, data:128'h332211, csum:8'h9A, exp_done:1'b1, exp_err:1'b0};
    tbl[1] = '{addr:8'h0E, len:8'h04, data:128'h04030201, csum:8'hF6, exp_done:1'b1, exp_err:1'b0};
    tbl[2] = '{addr:8'h05, len:8'h00, data:128'h0, csum:8'h88, exp_done:1'b1, exp_err:1'b0};
    for (int i = 0; i < 16; i++) tbl[2].data[8*i +: 8] = 8'h10 + 8'(i);
    tbl[3] = '{addr:8'h03, len:8'h02, data:128'h40A5, csum:8'h00, exp_done:1'b0, exp_err:1'b1};
    tbl[4] = '{addr:8'hF8, len:8'h01, data:128'h7F, csum:8'h81, exp_done:1'b1, exp_err:1'b0};

    repeat (3) step();
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_strobes", {mar_wr, ram_wr, bus_oe}, 0);
    chk("rst_bus_addr", {bus_out, mar_addr}, 0);
    chk("rst_flags", {cpu_hold, done, err}, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    send_byte(8'h33);
    chk("idle_drop_hold", cpu_hold, 0);
    chk("idle_drop_ready", rx_ready, 1);

    for (int t = 0; t < 5; t++) run_frame(tbl[t], t);

    // Per-byte strobe timing with address hold afterwards
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h5C);
    chk("k1_strobes", {mar_wr, ram_wr, bus_oe, rx_ready}, 4'b1000);
    chk("k1_addr", mar_addr, 2);
    step();
    chk("k2_strobes", {mar_wr, ram_wr, bus_oe, rx_ready}, 4'b0110);
    chk("k2_bus", bus_out, 8'h5C);
    step();
    chk("k3_strobes", {mar_wr, ram_wr, bus_oe, rx_ready}, 4'b0001);
    chk("k3_addr_hold", mar_addr, 2);
    exp_mem[2] = 8'h5C;
    send_byte(8'hA4);
    chk("k_done", done, 1);
    step();
    chk_mem("k_ram");

    // Stall after second data byte
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    step();
    step();
    repeat (TIMEOUT - 1) step();
    chk("to_before_hold", cpu_hold, 1);
    chk("to_before_err", err, 0);
    step();
    chk("to_hold", cpu_hold, 0);
    chk("to_err", err, 1);
    chk("to_ready", rx_ready, 1);
    exp_mem[0] = 8'h01;
    exp_mem[1] = 8'h02;
    chk_mem("to_ram");

    // Reset during the RAM write cycle
    send_byte(8'hA5);
    send_byte(8'h09);
    send_byte(8'h02);
    send_byte(8'h55);
    step();
    chk("rw_in_wr", ram_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_strobes", {mar_wr, ram_wr, bus_oe}, 0);
    chk("rw_hold", cpu_hold, 0);
    chk("rw_ready", rx_ready, 1);
    #3 rst_n = 1'b1;
    step();
    chk("rw_err_cleared", err, 0);
    chk_mem("rw_ram");

    run_frame(tbl[0], 5);
    chk("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
